// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 decoder.
//   DEC_IN_W / DEC_OUT_W : select and output widths
//   onehot_dec(sel, en)  : active-high one-hot decode, all-zero when disabled
//   idle_val(active_low) : output value when disabled or in reset
package decoder_pkg;
  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 4;

  localparam logic [DEC_OUT_W-1:0] IDLE_HI = '0;
  localparam logic [DEC_OUT_W-1:0] IDLE_LO = '1;

  // enable is tested first so an unknown select cannot leak through while disabled
  function automatic logic [DEC_OUT_W-1:0] onehot_dec(input logic [DEC_IN_W-1:0] sel,
                                                      input logic en);
    logic [DEC_OUT_W-1:0] res;
    res = '0;
    if (en) begin
      for (int i = 0; i < DEC_OUT_W; i++)
        if (sel == DEC_IN_W'(i)) res[i] = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [DEC_OUT_W-1:0] idle_val(input bit active_low);
    return active_low ? IDLE_LO : IDLE_HI;
  endfunction
endpackage

// File: rtl/decoder_2x4_core.sv
// Combinational 2-to-4 decode with output polarity selection.
//   in     : binary select code
//   enable : active-high decode enable
//   out    : one-hot word, inverted when OUT_ACTIVE_LOW=1
module decoder_2x4_core
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic [DEC_IN_W-1:0]  in,
  input  logic                 enable,
  output logic [DEC_OUT_W-1:0] out
);
  logic [DEC_OUT_W-1:0] dec;

  assign dec = onehot_dec(in, enable);
  assign out = OUT_ACTIVE_LOW ? ~dec : dec;
endmodule

// File: rtl/decoder_2x4.sv
// Registered (or optionally combinational) 2-to-4 decoder with enable.
//   clk    : rising-edge clock (only used when OUT_REG=1)
//   rst    : asynchronous active-high reset, forces out to idle
//   in     : binary select code
//   enable : active-high decode enable
//   out    : one-hot decoded output, polarity set by OUT_ACTIVE_LOW
module decoder_2x4
  import decoder_pkg::*;
#(
  parameter bit OUT_REG        = 1'b1,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEC_IN_W-1:0]  in,
  input  logic                 enable,
  output logic [DEC_OUT_W-1:0] out
);
  localparam logic [DEC_OUT_W-1:0] IDLE = idle_val(OUT_ACTIVE_LOW);

  logic [DEC_OUT_W-1:0] dec;

  decoder_2x4_core #(.OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)) u_core (
    .in     (in),
    .enable (enable),
    .out    (dec)
  );

  generate
    if (OUT_REG) begin : g_reg
      logic [DEC_OUT_W-1:0] out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= IDLE;
        else     out_q <= dec;
      end

      assign out = out_q;
    end else begin : g_comb
      // clk has no role in the bypass path
      logic unused_clk;
      assign unused_clk = clk;
      assign out = rst ? IDLE : dec;
    end
  endgenerate
endmodule

// File: tb/tb_decoder_2x4.sv
module tb_decoder_2x4;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic       enable;
  logic [3:0] out_r, out_al, out_c;

  int checks = 0;
  int errors = 0;

  // expected registered value (captured at the last rising edge)
  logic [3:0] exp_q;

  always #5 clk = ~clk;

  decoder_2x4 #(.OUT_REG(1'b1), .OUT_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .out(out_r));
  decoder_2x4 #(.OUT_REG(1'b1), .OUT_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .out(out_al));
  decoder_2x4 #(.OUT_REG(1'b0), .OUT_ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .out(out_c));

  // reference: enabled -> single bit at position of the select value, else nothing
  function automatic logic [3:0] ref_dec(input logic [1:0] sel, input logic en);
    if (en !== 1'b1) return 4'b0000;
    return 4'(2 ** int'(sel));
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_onehot(input string tag, input logic [3:0] obs);
    checks++;
    assert (!$isunknown(obs) && $countones(obs) <= 1)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected at most one bit set", tag, obs);
    end
  endtask

  // drive at falling edge, check combinational copy, then check registered copies after rising edge
  task automatic step(input string tag, input logic [1:0] s, input logic e);
    @(negedge clk);
    in = s; enable = e;
    #1;
    check({tag, "_comb"}, out_c, rst ? 4'b0000 : ref_dec(s, e));
    exp_q = ref_dec(s, e);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, out_r, exp_q);
    check({tag, "_al"}, out_al, ~exp_q);
    check_onehot({tag, "_onehot"}, out_r);
  endtask

  initial begin
    // reset with an active decode request pending
    rst = 1'b1; enable = 1'b1; in = 2'd3;
    #1;
    check("rst_reg", out_r, 4'b0000);
    check("rst_al", out_al, 4'b1111);
    check("rst_comb", out_c, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_reg", out_r, 4'b0000);
    check("rst_hold_al", out_al, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_reg", out_r, 4'b1000);
    check("rst_release_al", out_al, 4'b0111);

    // enabled and disabled sweeps
    for (int i = 0; i < 4; i++) step("en_sweep", 2'(i), 1'b1);
    for (int i = 0; i < 4; i++) step("dis_sweep", 2'(i), 1'b0);

    // enable toggles every 4 cycles while select keeps cycling
    for (int i = 0; i < 16; i++) step("toggle", 2'(i % 4), ((i / 4) % 2) == 0);

    // select unknown while disabled: enable must dominate
    @(negedge clk);
    in = 2'bxx; enable = 1'b0;
    #1;
    check("x_dis_comb", out_c, 4'b0000);
    @(posedge clk);
    #1;
    check("x_dis_reg", out_r, 4'b0000);
    check("x_dis_al", out_al, 4'b1111);

    // specific parameter-variant points
    step("al_in1", 2'd1, 1'b1);
    check("al_in1_exact", out_al, 4'b1101);
    @(negedge clk);
    in = 2'd2; enable = 1'b1;
    #1;
    check("comb_zero_lat", out_c, 4'b0100);

    // async reset between edges while out shows 0100
    @(posedge clk);
    #1;
    check("mid_pre_reg", out_r, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_reg", out_r, 4'b0000);
    check("mid_rst_al", out_al, 4'b1111);
    check("mid_rst_comb", out_c, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_comb", out_c, 4'b0100);
    @(posedge clk);
    #1;
    check("mid_rel_reg", out_r, 4'b0100);

    // randomized traffic against the reference
    for (int i = 0; i < 60; i++)
      step("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_2x4.md
Name: decoder_2x4

Overview:
Registered 2-to-4 line decoder with enable. It converts a 2-bit binary select into a one-hot 4-bit output word. It is used as a small address/strobe decoder feeding downstream chip-select or mux-select logic. The output is registered on clk by default, with an optional combinational bypass.

Parameters:
OUT_REG, 1, 1 = output registered (1-cycle latency); 0 = purely combinational output (clk/rst unused except as noted)
OUT_ACTIVE_LOW, 0, 0 = asserted output bit is 1; 1 = all output bits inverted (asserted bit is 0, idle is 4'b1111)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in  input  2  binary select code
enable  input  1  active-high decode enable
out  output  4  one-hot decoded output (polarity per OUT_ACTIVE_LOW)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Decode function, active-high form (OUT_ACTIVE_LOW=0):
  - enable=1: out = 4'b0001 << in, i.e. in=0 gives 0001, in=1 gives 0010, in=2 gives 0100, in=3 gives 1000.
  - enable=0: out = 4'b0000 regardless of in.
- OUT_ACTIVE_LOW=1: out is the bitwise inverse of the active-high value.
  - Disabled/idle = 4'b1111.
  - in=2 enabled = 4'b1011.
- OUT_REG=1:
  - Decoded value is captured on rising clk; out reflects the in/enable sampled at the previous edge (latency 1 cycle).
  - rst asserted drives out immediately (asynchronously) to the idle value: 4'b0000, or 4'b1111 if OUT_ACTIVE_LOW.
  - out holds idle while rst is high.
  - First capture occurs on the first rising edge after rst deasserts.
- OUT_REG=0:
  - out follows in/enable combinationally, with zero latency.
  - rst high still forces the idle value, combinationally.
- Invariant: at most one output bit is asserted at any time, never zero-latency glitch-free guaranteed only in OUT_REG=1.
- X/Z on in while enable=0: out must be idle (enable dominates).
- Reset mid-operation: out returns to idle within the same time step; no state is retained.
- enable and in changing on the same edge: both are sampled together; no ordering priority.

Decomposition:
- Shared package decoder_pkg:
  - localparam DEC_IN_W=2, DEC_OUT_W=4.
  - Function onehot_dec(sel, en) returning DEC_OUT_W-bit one-hot value.
  - Idle constant per polarity.
- Sub-module decoder_2x4_core: pure combinational decode plus polarity inversion.
- decoder_2x4 top: wraps the core with the optional reset-able output register, selected by a generate block on OUT_REG.

Test Plan:
- Reset: rst=1 with enable=1, in=3 -> out=0000 immediately, and stays 0000 across edges; after rst drops, next edge gives out=1000.
- Enabled sweep: enable=1, in stepping 0,1,2,3, one per cycle -> out 0001, 0010, 0100, 1000, each one cycle after its input (OUT_REG=1).
- Disabled sweep: enable=0, in stepping 0..3 -> out=0000 throughout.
- Enable toggle pattern: enable toggles every 4 cycles while in cycles 0..3 continuously -> out alternates between 4 cycles of one-hot sequence and 4 cycles of 0000; one-hot property is checked every cycle.
- Async reset mid-stream: assert rst between edges while out=0100 -> out=0000 before the next edge.
- Parameter variants: OUT_ACTIVE_LOW=1, enable=1, in=1 -> out=1101; disabled -> 1111. OUT_REG=0, in=2, enable=1 -> out=0100 with zero cycles of latency.
